// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit pipeline: data/address widths and the
// MEM-stage access controller state encoding.
package proc_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } mem_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Clearable saturating counter for the WAIT-state watchdog; o_tc is high
// during the LIMIT-th counted cycle (count == LIMIT-1).
module mem_timeout_ctr #(
   parameter int LIMIT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] TC_VAL = CW'(LIMIT - 1);

   logic [CW-1:0] r_count;

   // Holds at the terminal value so o_tc stays asserted until cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != TC_VAL)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller for a variable-latency data memory; stalls the pipeline
// while an access is outstanding. MEM_TIMEOUT_EN enables the WAIT watchdog.
module mem_access_ctrl
   import proc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRd,
   input  logic              MemWrt,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_stall,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              err,
   output logic [1:0]        dbg_state
);

   // Memory handshake: mem_en is a single-cycle request strobe (no ready);
   // the memory answers later with a one-cycle mem_done, honoured only in WAIT.
   // Towards the pipeline, mem_stall=0 in DONE is the one cycle the
   // instruction is allowed to advance out of MEM.

   mem_state_t        r_state;
   mem_state_t        w_next;
   logic              r_is_rd;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;

   logic w_access;
   logic w_illegal;
   logic w_capture;
   logic w_to_err;
   logic w_timeout;

   assign w_access  = MemRd | MemWrt;
   assign w_illegal = (MemRd & MemWrt) | (w_access & addr[0]);

`ifdef MEM_TIMEOUT_EN
   logic w_tc;

   mem_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk   (clk),
      .rst   (rst),
      .i_clr (r_state != WAIT),
      .i_en  ((r_state == WAIT) && !mem_done),
      .o_tc  (w_tc)
   );

   // A response in the limit cycle takes priority over the timeout.
   assign w_timeout = (r_state == WAIT) & w_tc & ~mem_done;
`else
   logic w_unused_cfg;

   assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
   assign w_timeout    = 1'b0;
`endif

   always_comb begin
      w_next      = r_state;
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = r_addr;
      mem_wdata   = '0;
      mem_stall   = 1'b0;
      rdata_valid = 1'b0;
      w_capture   = 1'b0;
      w_to_err    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_access) begin
               mem_stall = 1'b1;
               if (w_illegal) begin
                  w_to_err = 1'b1;
                  w_next   = ERR;
               end else begin
                  mem_en    = 1'b1;
                  mem_wr    = MemWrt;
                  mem_addr  = addr;
                  mem_wdata = wdata;
                  w_next    = WAIT;
               end
            end
         end
         WAIT: begin
            mem_stall = 1'b1;
            if (mem_done) begin
               w_capture = r_is_rd;
               w_next    = DONE;
            end else if (w_timeout) begin
               w_to_err = 1'b1;
               w_next   = ERR;
            end
         end
         DONE: begin
            // Always back to IDLE so the held instruction is not re-issued.
            rdata_valid = r_is_rd;
            w_next      = IDLE;
         end
         ERR: begin
            mem_stall = 1'b1;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_is_rd <= 1'b0;
         r_addr  <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (mem_en) begin
            r_is_rd <= ~MemWrt;
            r_addr  <= addr;
         end
         if (w_capture) begin
            r_rdata <= mem_rdata;
         end
         if (w_to_err) begin
            r_err <= 1'b1;
         end
      end
   end

   assign rdata     = r_rdata;
   assign err       = r_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a load-data scoreboard; the
// timeout section is compiled in only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;
   import proc_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemRd;
   logic        MemWrt;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        mem_done;
   logic [15:0] mem_rdata;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_stall;
   logic [15:0] rdata;
   logic        rdata_valid;
   logic        err;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_err    = 0;
   logic [15:0] exp_q[$];

   mem_access_ctrl #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .MemRd       (MemRd),
      .MemWrt      (MemWrt),
      .addr        (addr),
      .wdata       (wdata),
      .mem_done    (mem_done),
      .mem_rdata   (mem_rdata),
      .mem_en      (mem_en),
      .mem_wr      (mem_wr),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_stall   (mem_stall),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .err         (err),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      MemRd     = 1'b0;
      MemWrt    = 1'b0;
      addr      = 16'h0000;
      wdata     = 16'h0000;
      mem_done  = 1'b0;
      mem_rdata = 16'h0000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   // Called just after a rising edge (cycle 0). Returns at the falling edge
   // of the DONE cycle with the instruction's inputs still held.
   task automatic run_access(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [15:0] d, input int n, input logic [15:0] rdat);
      logic [15:0] exp_d;
      MemRd  = rd;
      MemWrt = wr;
      addr   = a;
      wdata  = d;
      if (rd) exp_q.push_back(rdat);
      @(negedge clk);
      check("issue_en", mem_en, 1'b1);
      check("issue_wr", mem_wr, wr);
      check("issue_addr", mem_addr, a);
      if (wr) check("issue_wdata", mem_wdata, d);
      check("issue_stall", mem_stall, 1'b1);
      for (int c = 1; c <= n; c++) begin
         next_cycle();
         mem_done  = (c == n);
         mem_rdata = (c == n) ? rdat : ~rdat;
         @(negedge clk);
         check("wait_state", dbg_state, WAIT);
         check("wait_en", mem_en, 1'b0);
         check("wait_stall", mem_stall, 1'b1);
      end
      next_cycle();
      mem_done  = 1'b0;
      mem_rdata = 16'hDEAD;
      @(negedge clk);
      check("done_state", dbg_state, DONE);
      check("done_stall", mem_stall, 1'b0);
      check("done_en", mem_en, 1'b0);
      check("done_rdv", rdata_valid, rd);
      if (rdata_valid === 1'b1 && exp_q.size() > 0) begin
         exp_d = exp_q.pop_front();
         check("sb_rdata", rdata, exp_d);
      end
   endtask

   task automatic check_idle(input logic [15:0] exp_rdata);
      @(negedge clk);
      check("idle_state", dbg_state, IDLE);
      check("idle_en", mem_en, 1'b0);
      check("idle_stall", mem_stall, 1'b0);
      check("idle_rdv", rdata_valid, 1'b0);
      check("idle_rdata_hold", rdata, exp_rdata);
   endtask

   task automatic check_err_response(input logic rd, input logic wr, input logic [15:0] a);
      next_cycle();
      MemRd  = rd;
      MemWrt = wr;
      addr   = a;
      @(negedge clk);
      check("bad_en", mem_en, 1'b0);
      check("bad_stall", mem_stall, 1'b1);
      next_cycle();
      @(negedge clk);
      check("bad_state", dbg_state, ERR);
      check("bad_err", err, 1'b1);
      check("bad_en2", mem_en, 1'b0);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         MemRd    = 1'b0;
         MemWrt   = 1'b0;
         mem_done = 1'b1;
         @(negedge clk);
         check("err_hold_state", dbg_state, ERR);
         check("err_hold_stall", mem_stall, 1'b1);
         check("err_hold_err", err, 1'b1);
         check("err_hold_en", mem_en, 1'b0);
      end
      do_reset();
      @(negedge clk);
      check("post_rst_state", dbg_state, IDLE);
      check("post_rst_err", err, 1'b0);
      check("post_rst_stall", mem_stall, 1'b0);
   endtask

   initial begin
      logic        r_rd;
      logic [15:0] r_a;
      logic [15:0] r_d;
      logic [15:0] last_rd;
      int          r_n;

      rst = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_en", mem_en, 1'b0);
      check("rst_wr", mem_wr, 1'b0);
      check("rst_stall", mem_stall, 1'b0);
      check("rst_rdv", rdata_valid, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_rdata", rdata, 16'h0000);
      check("rst_addr", mem_addr, 16'h0000);
      check("rst_wdata", mem_wdata, 16'h0000);
      check("rst_state", dbg_state, IDLE);
      next_cycle();
      rst = 1'b0;

      // load with response in cycle 3
      next_cycle();
      run_access(1'b1, 1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF);
      next_cycle();
      idle_inputs();
      check_idle(16'hBEEF);

      // store with response in cycle 1
      next_cycle();
      run_access(1'b0, 1'b1, 16'h0020, 16'h1234, 1, 16'h0000);
      next_cycle();
      idle_inputs();
      check_idle(16'hBEEF);

      // back-to-back load then store
      next_cycle();
      run_access(1'b1, 1'b0, 16'h0100, 16'h0000, 2, 16'hA5A5);
      next_cycle();
      run_access(1'b0, 1'b1, 16'h0102, 16'h5A5A, 2, 16'h0000);
      next_cycle();
      idle_inputs();
      check_idle(16'hA5A5);

      // randomised back-to-back traffic
      last_rd = 16'hA5A5;
      for (int i = 0; i < 6; i++) begin
         r_rd = 1'($urandom_range(0, 1));
         r_a  = 16'($urandom_range(0, 16'h7FFF)) << 1;
         r_d  = 16'($urandom_range(0, 16'hFFFF));
         r_n  = $urandom_range(1, TO);
         next_cycle();
         run_access(r_rd, ~r_rd, r_a, r_d, r_n, r_d ^ 16'h3C3C);
         if (r_rd) last_rd = r_d ^ 16'h3C3C;
      end
      next_cycle();
      idle_inputs();
      check_idle(last_rd);

      // reset while waiting, late response must be ignored
      next_cycle();
      MemRd = 1'b1;
      addr  = 16'h0030;
      @(negedge clk);
      check("rw_issue_en", mem_en, 1'b1);
      next_cycle();
      @(negedge clk);
      check("rw_wait1", dbg_state, WAIT);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      check("rw_wait2", dbg_state, WAIT);
      next_cycle();
      rst       = 1'b0;
      MemRd     = 1'b0;
      mem_done  = 1'b1;
      mem_rdata = 16'h5555;
      check_idle(16'h0000);
      next_cycle();
      mem_done = 1'b0;
      check_idle(16'h0000);

      // misaligned address, then read+write together
      check_err_response(1'b1, 1'b0, 16'h0011);
      check_err_response(1'b1, 1'b1, 16'h0040);

`ifdef MEM_TIMEOUT_EN
      // no response: error after TO wait cycles
      next_cycle();
      MemRd = 1'b1;
      addr  = 16'h0050;
      @(negedge clk);
      check("to_issue_en", mem_en, 1'b1);
      for (int c = 1; c <= TO; c++) begin
         next_cycle();
         @(negedge clk);
         check("to_wait_state", dbg_state, WAIT);
         check("to_wait_err", err, 1'b0);
      end
      next_cycle();
      @(negedge clk);
      check("to_err_state", dbg_state, ERR);
      check("to_err_flag", err, 1'b1);
      check("to_err_stall", mem_stall, 1'b1);
      do_reset();

      // response in the limit cycle wins
      next_cycle();
      run_access(1'b1, 1'b0, 16'h0052, 16'h0000, TO, 16'hC0DE);
      check("to_limit_err", err, 1'b0);
      next_cycle();
      idle_inputs();
      check_idle(16'hC0DE);
`endif

      check("sb_drain", 16'(exp_q.size()), 16'h0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
